// File: rtl/check_node_scheduler_pkg.sv
// Shared definitions for the check-node frame scheduler: FSM state encoding
// and default datapath widths / flush length.
package check_node_scheduler_pkg;

   localparam int unsigned LLR_WIDTH_DEF    = 6;  // LLR MSB index
   localparam int unsigned Q_WIDTH_DEF      = 5;  // symbol MSB index
   localparam int unsigned FLUSH_CYCLES_DEF = 2;  // node reset length between frames

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

endpackage

// File: rtl/check_node_scheduler_msg_feeder.sv
// Single-stream message feeder: accepts up to deg messages from a source
// while active, forwarding each one to the node as a one-cycle write with
// one cycle of latency.
// Ports:
//   clk, rst           clock, async active-high reset
//   clear, deg         latch the frame degree and zero the count
//   active             stream may accept (scheduler is loading)
//   src_valid/llr/q    source message
//   node_ready         node reports this store already loaded
//   src_ready_c        combinational accept strobe back to the source
//   write, llr, q      registered write to the node
//   complete_c         combinational: side has nothing more to accept
module check_node_scheduler_msg_feeder #(
   parameter int unsigned LLR_Width     = 6,
   parameter int unsigned Q_Width       = 5,
   parameter int unsigned Counter_Width = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic [Counter_Width-1:0] deg,
   input  logic                     active,
   input  logic                     src_valid,
   input  logic [LLR_Width:0]       src_llr,
   input  logic [Q_Width:0]         src_q,
   input  logic                     node_ready,
   output logic                     src_ready_c,
   output logic                     write,
   output logic [LLR_Width:0]       llr,
   output logic [Q_Width:0]         q,
   output logic                     complete_c
);

   localparam int unsigned CW = Counter_Width;

   logic [CW-1:0] deg_q;
   logic [CW-1:0] cnt_q;

   // Side is done once the frame degree is met or the node says it is loaded.
   assign complete_c  = (cnt_q == deg_q) || node_ready;
   assign src_ready_c = active && src_valid && !complete_c;

   // Count accepts and register the accepted message for the node.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deg_q <= '0;
         cnt_q <= '0;
         write <= 1'b0;
         llr   <= '0;
         q     <= '0;
      end else begin
         write <= src_ready_c;
         if (clear) begin
            deg_q <= deg;
            cnt_q <= '0;
         end else if (src_ready_c) begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (src_ready_c) begin
            llr <= src_llr;
            q   <= src_q;
         end
      end
   end

endmodule

// File: rtl/check_node_scheduler.sv
// Frame-level controller for one check node. Meters the A and I message
// streams into the node, opens the node output and counts filtered results
// until the frame completes or goes idle too long, then holds the node in
// reset for a few cycles and pulses done.
// Ports:
//   clk, force_reset                 clock, async active-high reset
//   start, deg_a, deg_i, n_out       frame command (accepted only when idle)
//   src_{a,i}_valid/llr/q/ready      message sources (ready is combinational)
//   write_{A,I}, Input_LLR_*, Input_Q_*  node message writes
//   A_ready, I_ready                 node stores loaded
//   receivable                       node output may advance
//   Output_Valid                     one filtered output this cycle
//   full                             node stores full (informational)
//   force_reset_n                    active-low node reset
//   busy, done, timeout_err, out_count  frame status
module check_node_scheduler
   import check_node_scheduler_pkg::*;
#(
   parameter int unsigned LLR_Width     = LLR_WIDTH_DEF,
   parameter int unsigned Q_Width       = Q_WIDTH_DEF,
   parameter int unsigned Counter_Width = 4,
   parameter int unsigned Timeout_Width = 8,
   parameter int unsigned Flush_Cycles  = FLUSH_CYCLES_DEF
) (
   input  logic                     clk,
   input  logic                     force_reset,
   input  logic                     start,
   input  logic [Counter_Width-1:0] deg_a,
   input  logic [Counter_Width-1:0] deg_i,
   input  logic [Counter_Width-1:0] n_out,
   input  logic                     src_a_valid,
   input  logic [LLR_Width:0]       src_a_llr,
   input  logic [Q_Width:0]         src_a_q,
   output logic                     src_a_ready,
   input  logic                     src_i_valid,
   input  logic [LLR_Width:0]       src_i_llr,
   input  logic [Q_Width:0]         src_i_q,
   output logic                     src_i_ready,
   output logic                     write_A,
   output logic [LLR_Width:0]       Input_LLR_A,
   output logic [Q_Width:0]         Input_Q_A,
   output logic                     write_I,
   output logic [LLR_Width:0]       Input_LLR_I,
   output logic [Q_Width:0]         Input_Q_I,
   input  logic                     A_ready,
   input  logic                     I_ready,
   output logic                     receivable,
   input  logic                     Output_Valid,
   input  logic                     full,
   output logic                     force_reset_n,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout_err,
   output logic [Counter_Width-1:0] out_count
);

   localparam int unsigned CW      = Counter_Width;
   localparam int unsigned TW      = Timeout_Width;
   localparam int unsigned FLUSH_W = $clog2(Flush_Cycles + 1);

   state_t        state_q, state_d;
   logic [CW-1:0] n_out_q;
   logic [CW-1:0] out_count_d;
   logic [TW-1:0] idle_q, idle_d;
   logic [FLUSH_W-1:0] flush_q, flush_d;
   logic          timeout_d;
   logic          accept_start;
   logic          loading;
   logic          a_complete, i_complete;

   // Load completion is already signalled per store by A_ready / I_ready.
   logic unused_full;
   assign unused_full = full;

   assign accept_start = (state_q == ST_IDLE) && start;
   assign loading      = (state_q == ST_LOAD);

   check_node_scheduler_msg_feeder #(
      .LLR_Width     (LLR_Width),
      .Q_Width       (Q_Width),
      .Counter_Width (Counter_Width)
   ) u_feed_a (
      .clk         (clk),
      .rst         (force_reset),
      .clear       (accept_start),
      .deg         (deg_a),
      .active      (loading),
      .src_valid   (src_a_valid),
      .src_llr     (src_a_llr),
      .src_q       (src_a_q),
      .node_ready  (A_ready),
      .src_ready_c (src_a_ready),
      .write       (write_A),
      .llr         (Input_LLR_A),
      .q           (Input_Q_A),
      .complete_c  (a_complete)
   );

   check_node_scheduler_msg_feeder #(
      .LLR_Width     (LLR_Width),
      .Q_Width       (Q_Width),
      .Counter_Width (Counter_Width)
   ) u_feed_i (
      .clk         (clk),
      .rst         (force_reset),
      .clear       (accept_start),
      .deg         (deg_i),
      .active      (loading),
      .src_valid   (src_i_valid),
      .src_llr     (src_i_llr),
      .src_q       (src_i_q),
      .node_ready  (I_ready),
      .src_ready_c (src_i_ready),
      .write       (write_I),
      .llr         (Input_LLR_I),
      .q           (Input_Q_I),
      .complete_c  (i_complete)
   );

   // Next-state and next counter values.
   always_comb begin
      state_d     = state_q;
      out_count_d = out_count;
      idle_d      = idle_q;
      flush_d     = flush_q;
      timeout_d   = timeout_err;
      case (state_q)
         ST_IDLE: begin
            if (accept_start) begin
               state_d     = ST_LOAD;
               out_count_d = '0;
               idle_d      = '0;
               flush_d     = '0;
               timeout_d   = 1'b0;
            end
         end
         ST_LOAD: begin
            // Wait for the last registered write to reach the node as well.
            if (a_complete && i_complete && !write_A && !write_I) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (n_out_q == '0) begin
               state_d = ST_FLUSH;
               flush_d = '0;
            end else begin
               if (Output_Valid) begin
                  out_count_d = (out_count == '1) ? out_count : out_count + CW'(1);
                  idle_d      = '0;
               end else begin
                  idle_d = idle_q + TW'(1);
               end
               if (out_count_d == n_out_q) begin
                  state_d = ST_FLUSH;
                  flush_d = '0;
               end else if (&idle_d) begin
                  state_d   = ST_FLUSH;
                  flush_d   = '0;
                  timeout_d = 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            flush_d = flush_q + FLUSH_W'(1);
            if (flush_q == FLUSH_W'(Flush_Cycles - 1)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register and registered frame status outputs.
   always_ff @(posedge clk or posedge force_reset) begin
      if (force_reset) begin
         state_q       <= ST_IDLE;
         n_out_q       <= '0;
         out_count     <= '0;
         idle_q        <= '0;
         flush_q       <= '0;
         timeout_err   <= 1'b0;
         busy          <= 1'b0;
         receivable    <= 1'b0;
         done          <= 1'b0;
         force_reset_n <= 1'b0;
      end else begin
         state_q       <= state_d;
         out_count     <= out_count_d;
         idle_q        <= idle_d;
         flush_q       <= flush_d;
         timeout_err   <= timeout_d;
         if (accept_start) begin
            n_out_q <= n_out;
         end
         busy          <= (state_d != ST_IDLE);
         receivable    <= (state_d == ST_DRAIN);
         done          <= (state_q == ST_FLUSH) && (state_d == ST_IDLE);
         force_reset_n <= (state_d != ST_FLUSH);
      end
   end

endmodule

// File: tb/tb_check_node_scheduler.sv
// Scoreboard bench for check_node_scheduler: random frames, random source
// traffic and output traffic; expected writes and frame results are queued
// and checked by a negedge monitor.
module tb_check_node_scheduler;

   localparam int unsigned LW = 6;
   localparam int unsigned QW = 5;
   localparam int unsigned CW = 4;
   localparam int unsigned TW = 8;
   localparam int unsigned FC = 2;
   localparam int unsigned IDLE_LIMIT = (1 << TW) - 1;

   logic          clk = 1'b0;
   logic          force_reset = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] deg_a = '0, deg_i = '0, n_out = '0;
   logic          src_a_valid = 1'b0, src_i_valid = 1'b0;
   logic [LW:0]   src_a_llr = '0, src_i_llr = '0;
   logic [QW:0]   src_a_q = '0, src_i_q = '0;
   logic          src_a_ready, src_i_ready;
   logic          write_A, write_I;
   logic [LW:0]   Input_LLR_A, Input_LLR_I;
   logic [QW:0]   Input_Q_A, Input_Q_I;
   logic          A_ready = 1'b0, I_ready = 1'b0;
   logic          receivable;
   logic          Output_Valid = 1'b0;
   logic          full = 1'b0;
   logic          force_reset_n, busy, done, timeout_err;
   logic [CW-1:0] out_count;

   always #5 clk = ~clk;

   check_node_scheduler dut (
      .clk           (clk),
      .force_reset   (force_reset),
      .start         (start),
      .deg_a         (deg_a),
      .deg_i         (deg_i),
      .n_out         (n_out),
      .src_a_valid   (src_a_valid),
      .src_a_llr     (src_a_llr),
      .src_a_q       (src_a_q),
      .src_a_ready   (src_a_ready),
      .src_i_valid   (src_i_valid),
      .src_i_llr     (src_i_llr),
      .src_i_q       (src_i_q),
      .src_i_ready   (src_i_ready),
      .write_A       (write_A),
      .Input_LLR_A   (Input_LLR_A),
      .Input_Q_A     (Input_Q_A),
      .write_I       (write_I),
      .Input_LLR_I   (Input_LLR_I),
      .Input_Q_I     (Input_Q_I),
      .A_ready       (A_ready),
      .I_ready       (I_ready),
      .receivable    (receivable),
      .Output_Valid  (Output_Valid),
      .full          (full),
      .force_reset_n (force_reset_n),
      .busy          (busy),
      .done          (done),
      .timeout_err   (timeout_err),
      .out_count     (out_count)
   );

   typedef struct {
      int unsigned due;
      logic [LW:0] llr;
      logic [QW:0] q;
   } wr_t;

   typedef struct {
      int unsigned deg_a;
      int unsigned deg_i;
      int unsigned n_out;
      int unsigned exp_count;
      bit          a_exact;
      bit          exp_to;
   } frame_t;

   wr_t    exp_a[$];
   wr_t    exp_i[$];
   frame_t exp_f[$];

   int unsigned n_cmp = 0, n_bad = 0, cyc = 0;
   int unsigned wr_a_seen = 0, wr_i_seen = 0;
   int unsigned drain_cycles = 0, idle_run = 0, low_cnt = 0, frames_done = 0;
   int unsigned a_thresh = 0, ov_left = 0;
   bit          always_valid = 1'b0;
   bit          prev_recv = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: scoreboard for node writes, frame results and handshake rules.
   always @(negedge clk) begin
      wr_t    e;
      frame_t f;
      if (force_reset) begin
         check("rst_force_reset_n", force_reset_n, 0);
         check("rst_busy", busy, 0);
         check("rst_write_A", write_A, 0);
         check("rst_write_I", write_I, 0);
         check("rst_done", done, 0);
         check("rst_receivable", receivable, 0);
         check("rst_out_count", out_count, 0);
         check("rst_timeout_err", timeout_err, 0);
         check("rst_src_ready", {src_a_ready, src_i_ready}, 0);
         prev_recv = 1'b0;
      end else begin
         // Sources are only consumed while loading.
         check("a_ready_outside_load", src_a_ready && (!busy || receivable), 0);
         check("i_ready_outside_load", src_i_ready && (!busy || receivable), 0);
         if (A_ready && busy) check("a_ready_after_loaded", src_a_ready, 0);

         if (write_A) begin
            if (exp_a.size() == 0) check("write_a_unexpected", 1, 0);
            else begin
               e = exp_a.pop_front();
               check("write_a_latency", cyc, e.due);
               check("write_a_llr", Input_LLR_A, e.llr);
               check("write_a_q", Input_Q_A, e.q);
               wr_a_seen++;
            end
         end else if (exp_a.size() != 0 && exp_a[0].due <= cyc) begin
            check("write_a_missing", 0, 1);
            void'(exp_a.pop_front());
         end
         if (write_I) begin
            if (exp_i.size() == 0) check("write_i_unexpected", 1, 0);
            else begin
               e = exp_i.pop_front();
               check("write_i_latency", cyc, e.due);
               check("write_i_llr", Input_LLR_I, e.llr);
               check("write_i_q", Input_Q_I, e.q);
               wr_i_seen++;
            end
         end else if (exp_i.size() != 0 && exp_i[0].due <= cyc) begin
            check("write_i_missing", 0, 1);
            void'(exp_i.pop_front());
         end

         if (src_a_valid && src_a_ready) exp_a.push_back('{cyc + 1, src_a_llr, src_a_q});
         if (src_i_valid && src_i_ready) exp_i.push_back('{cyc + 1, src_i_llr, src_i_q});

         if (receivable && !prev_recv && exp_f.size() != 0) begin
            f = exp_f[0];
            if (f.a_exact) check("load_writes_a", wr_a_seen, f.deg_a);
            else           check("load_writes_a_bound", wr_a_seen <= f.deg_a, 1);
            check("load_writes_i", wr_i_seen, f.deg_i);
         end
         prev_recv = receivable;

         if (receivable) begin
            drain_cycles++;
            if (Output_Valid) idle_run = 0;
            else              idle_run++;
         end
         if (busy && !force_reset_n) begin
            low_cnt++;
            check("flush_receivable", receivable, 0);
         end

         if (done) begin
            if (exp_f.size() == 0) check("unexpected_done", 1, 0);
            else begin
               f = exp_f.pop_front();
               check("done_out_count", out_count, f.exp_count);
               check("done_timeout_err", timeout_err, f.exp_to);
               check("flush_low_cycles", low_cnt, FC);
               check("done_busy", busy, 0);
               check("done_force_reset_n", force_reset_n, 1);
               if (f.exp_to) check("timeout_idle_cycles", idle_run, IDLE_LIMIT);
               if (f.n_out == 0) check("zero_nout_drain", drain_cycles, 1);
               frames_done++;
            end
         end
      end
   end

   // One clock of stimulus: random source traffic, node/filter responses.
   task automatic step();
      @(posedge clk);
      #1;
      src_a_valid = always_valid || ($urandom_range(0, 3) != 0);
      src_i_valid = always_valid || ($urandom_range(0, 3) != 0);
      src_a_llr   = (LW+1)'($urandom);
      src_i_llr   = (LW+1)'($urandom);
      src_a_q     = (QW+1)'($urandom);
      src_i_q     = (QW+1)'($urandom);
      A_ready     = (a_thresh != 0) && (wr_a_seen >= a_thresh);
      if (receivable) begin
         Output_Valid = (ov_left != 0) && ($urandom_range(0, 2) != 0);
         if (Output_Valid) ov_left--;
      end else begin
         // Stray outputs outside the drain window must be ignored.
         Output_Valid = ($urandom_range(0, 3) == 0);
      end
   endtask

   task automatic do_reset(input int unsigned cycles);
      force_reset = 1'b1;
      exp_a.delete();
      exp_i.delete();
      exp_f.delete();
      ov_left = 0;
      repeat (cycles) step();
      force_reset = 1'b0;
      check("frn_before_clock", force_reset_n, 0);
      step();
      check("frn_after_release", force_reset_n, 1);
      check("idle_after_reset", busy, 0);
   endtask

   // Issue one frame; to_mode delivers only k < no outputs so it must time out.
   task automatic run_frame(input int unsigned da, input int unsigned di, input int unsigned no,
                            input bit to_mode, input int unsigned k,
                            input int unsigned thr, input bit av);
      frame_t      f;
      int unsigned waited;
      int unsigned base;
      waited = 0;
      while (busy && waited < 2000) begin
         step();
         waited++;
      end
      a_thresh     = thr;
      always_valid = av;
      wr_a_seen    = 0;
      wr_i_seen    = 0;
      drain_cycles = 0;
      idle_run     = 0;
      low_cnt      = 0;
      ov_left      = to_mode ? k : no;
      f.deg_a      = da;
      f.deg_i      = di;
      f.n_out      = no;
      f.exp_count  = to_mode ? k : no;
      f.a_exact    = (thr == 0);
      f.exp_to     = to_mode;
      exp_f.push_back(f);
      base  = frames_done;
      deg_a = CW'(da);
      deg_i = CW'(di);
      n_out = CW'(no);
      start = 1'b1;
      step();
      start  = 1'b0;
      waited = 0;
      while (frames_done == base && waited < 1500) begin
         if (busy && $urandom_range(0, 15) == 0) begin
            start = 1'b1;
            deg_a = CW'($urandom);
            deg_i = CW'($urandom);
            n_out = CW'($urandom);
         end
         step();
         start = 1'b0;
         waited++;
      end
      if (frames_done == base) begin
         check("frame_completed", 0, 1);
         do_reset(2);
      end
   endtask

   initial begin
      frame_t      f;
      int unsigned no;
      bit          to;
      do_reset(3);

      run_frame(3, 2, 4, 1'b0, 0, 0, 1'b1);
      run_frame(5, 3, 2, 1'b0, 0, 2, 1'b1);
      run_frame(2, 2, 4, 1'b1, 0, 0, 1'b0);
      run_frame(0, 0, 0, 1'b0, 0, 0, 1'b0);
      run_frame(15, 15, 15, 1'b0, 0, 0, 1'b0);
      run_frame(1, 4, 9, 1'b1, 3, 0, 1'b0);

      // Reset in the middle of loading: frame is abandoned without done.
      a_thresh     = 0;
      always_valid = 1'b1;
      ov_left      = 0;
      f = '{deg_a: 10, deg_i: 10, n_out: 3, exp_count: 3, a_exact: 1'b1, exp_to: 1'b0};
      exp_f.push_back(f);
      deg_a = CW'(10);
      deg_i = CW'(10);
      n_out = CW'(3);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      check("midload_busy", busy, 1);
      do_reset(2);
      repeat (12) step();
      check("post_reset_write_a", write_A, 0);
      check("post_reset_idle", busy, 0);

      for (int n = 0; n < 25; n++) begin
         no = $urandom_range(0, 15);
         to = (no != 0) && ($urandom_range(0, 4) == 0);
         run_frame($urandom_range(0, 15), $urandom_range(0, 15), no, to,
                   to ? $urandom_range(0, no - 1) : 0,
                   ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0,
                   1'(($urandom_range(0, 1))));
      end
      repeat (5) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
